// File: rtl/ahb_bridge_slave_if.sv
// ahb_bridge_slave_if: AHB-Lite slave front end that decodes APB windows and stalls AHB until the APB FSM finishes.
// Define AHB_SLV_ERR_RESP_EN to give unmapped accesses a two-cycle ERROR response instead of ignoring them.
module ahb_bridge_slave_if #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                NUM_SLV   = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                SLV_AW    = 16
) (
    input  logic               HCLK,
    input  logic               HRESET,
    input  logic               HREADYIN,
    input  logic [1:0]         HTRANS,
    input  logic [ADDR_W-1:0]  HADDR,
    input  logic               HWRITE,
    input  logic [2:0]         HSIZE,
    input  logic [DATA_W-1:0]  HWDATA,
    input  logic               XFER_DONE,
    input  logic [DATA_W-1:0]  PRDATA_IN,
    output logic               HREADYOUT,
    output logic [1:0]         HRESP,
    output logic [DATA_W-1:0]  HRDATA,
    output logic [ADDR_W-1:0]  PIPELINE_HADDR,
    output logic [DATA_W-1:0]  PIPELINE_HWDATA,
    output logic               HWRITEREG,
    output logic [2:0]         HSIZEREG,
    output logic [NUM_SLV-1:0] HSEL,
    output logic               VALID
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_DPH,
        S_WAITX
`ifdef AHB_SLV_ERR_RESP_EN
        ,
        S_ERR1,
        S_ERR2
`endif
    } state_t;

    state_t              r_state, w_next;
    logic [ADDR_W-1:0]   r_haddr;
    logic [DATA_W-1:0]   r_hwdata, r_hrdata;
    logic                r_hwrite;
    logic [2:0]          r_hsize;
    logic [NUM_SLV-1:0]  r_hsel, w_hsel;
    logic [ADDR_W:0]     w_off;
    logic [ADDR_W-1:0]   w_idx;
    logic                w_mapped, w_trans_ok, w_open, w_acc, w_acc_map;

    // Extra top bit catches addresses below BASE_ADDR instead of wrapping them into a window
    assign w_off      = {1'b0, HADDR} - {1'b0, BASE_ADDR};
    assign w_idx      = w_off[ADDR_W-1:0] >> SLV_AW;
    assign w_mapped   = !w_off[ADDR_W] && (w_idx < ADDR_W'(NUM_SLV));
    assign w_trans_ok = (HTRANS == 2'b10) || (HTRANS == 2'b11);

    genvar g;
    generate
        for (g = 0; g < NUM_SLV; g++) begin : g_sel
            assign w_hsel[g] = (w_idx == ADDR_W'(g));
        end
    endgenerate

`ifdef AHB_SLV_ERR_RESP_EN
    assign w_open    = (r_state == S_IDLE) || (r_state == S_ERR2);
    assign HREADYOUT = w_open;
    assign HRESP     = (r_state == S_ERR1 || r_state == S_ERR2) ? 2'b01 : 2'b00;
`else
    assign w_open    = (r_state == S_IDLE);
    assign HREADYOUT = w_open;
    assign HRESP     = 2'b00;
`endif
    assign w_acc     = w_open && HREADYOUT && HREADYIN && w_trans_ok;
    assign w_acc_map = w_acc && w_mapped;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_DPH:   w_next = S_WAITX;
            S_WAITX: w_next = XFER_DONE ? S_IDLE : S_WAITX;
`ifdef AHB_SLV_ERR_RESP_EN
            S_ERR1:  w_next = S_ERR2;
`endif
            default: begin
                w_next = S_IDLE;
                if (w_acc_map) w_next = S_DPH;
`ifdef AHB_SLV_ERR_RESP_EN
                else if (w_acc) w_next = S_ERR1;
`endif
            end
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_state  <= S_IDLE;
            r_haddr  <= '0;
            r_hwdata <= '0;
            r_hrdata <= '0;
            r_hwrite <= 1'b0;
            r_hsize  <= '0;
            r_hsel   <= '0;
        end else begin
            r_state <= w_next;
            if (w_acc_map) begin
                r_haddr  <= HADDR;
                r_hwrite <= HWRITE;
                r_hsize  <= HSIZE;
                r_hsel   <= w_hsel;
            end
            if (r_state == S_DPH && r_hwrite) r_hwdata <= HWDATA;
            if (r_state == S_WAITX && XFER_DONE) begin
                r_hsel <= '0;
                if (!r_hwrite) r_hrdata <= PRDATA_IN;
            end
        end
    end

    assign VALID           = (r_state == S_WAITX);
    assign HSEL            = r_hsel;
    assign HRDATA          = r_hrdata;
    assign PIPELINE_HADDR  = r_haddr;
    assign PIPELINE_HWDATA = r_hwdata;
    assign HWRITEREG       = r_hwrite;
    assign HSIZEREG        = r_hsize;
endmodule

// File: tb/tb_ahb_bridge_slave_if.sv
// tb_ahb_bridge_slave_if: directed bench for the AHB slave front end, default and 8-window instances.
module tb_ahb_bridge_slave_if;
    logic        clk = 1'b0, rst = 1'b1;
    logic        hreadyin = 1'b1, hwrite = 1'b0, xfer_done = 1'b0;
    logic [1:0]  htrans = 2'b00;
    logic [31:0] haddr = '0, hwdata = '0, prdata = '0;
    logic [2:0]  hsize = 3'd2;
    logic        a_rdy, a_wreg, a_valid, b_rdy, b_wreg, b_valid;
    logic [1:0]  a_resp, b_resp;
    logic [31:0] a_rdata, a_paddr, a_pwdata, b_rdata, b_paddr, b_pwdata;
    logic [2:0]  a_size, b_size;
    logic [3:0]  a_sel;
    logic [7:0]  b_sel;
    int          n_run = 0, n_fail = 0;
    logic [1:0]  err_resp;
    logic        err_rdy1;

    always #5 clk = ~clk;

    ahb_bridge_slave_if u_dut (
        .HCLK(clk), .HRESET(rst), .HREADYIN(hreadyin), .HTRANS(htrans), .HADDR(haddr),
        .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .XFER_DONE(xfer_done), .PRDATA_IN(prdata),
        .HREADYOUT(a_rdy), .HRESP(a_resp), .HRDATA(a_rdata), .PIPELINE_HADDR(a_paddr),
        .PIPELINE_HWDATA(a_pwdata), .HWRITEREG(a_wreg), .HSIZEREG(a_size), .HSEL(a_sel), .VALID(a_valid)
    );

    ahb_bridge_slave_if #(.NUM_SLV(8), .SLV_AW(12), .BASE_ADDR(32'h4000_0000)) u_dut8 (
        .HCLK(clk), .HRESET(rst), .HREADYIN(hreadyin), .HTRANS(htrans), .HADDR(haddr),
        .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .XFER_DONE(xfer_done), .PRDATA_IN(prdata),
        .HREADYOUT(b_rdy), .HRESP(b_resp), .HRDATA(b_rdata), .PIPELINE_HADDR(b_paddr),
        .PIPELINE_HWDATA(b_pwdata), .HWRITEREG(b_wreg), .HSIZEREG(b_size), .HSEL(b_sel), .VALID(b_valid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
`ifdef AHB_SLV_ERR_RESP_EN
        err_resp = 2'b01;
        err_rdy1 = 1'b0;
`else
        err_resp = 2'b00;
        err_rdy1 = 1'b1;
`endif
        step();
        step();
        chk("rst_rdy", 32'(a_rdy), 32'd1);
        chk("rst_resp", 32'(a_resp), 32'd0);
        chk("rst_valid", 32'(a_valid), 32'd0);
        chk("rst_hsel", 32'(a_sel), 32'd0);
        chk("rst_rdata", a_rdata, 32'd0);
        rst = 1'b0;
        step();
        // mapped write, XFER_DONE at T2
        htrans = 2'b10; haddr = 32'h0001_0004; hwrite = 1'b1; hsize = 3'd2;
        chk("wr_t0_rdy", 32'(a_rdy), 32'd1);
        step();
        htrans = 2'b00; hwdata = 32'hDEAD_BEEF;
        chk("wr_t1_rdy", 32'(a_rdy), 32'd0);
        chk("wr_t1_hsel", 32'(a_sel), 32'h2);
        chk("wr_t1_addr", a_paddr, 32'h0001_0004);
        chk("wr_t1_wreg", 32'(a_wreg), 32'd1);
        chk("wr_t1_size", 32'(a_size), 32'd2);
        chk("wr_t1_valid", 32'(a_valid), 32'd0);
        step();
        hwdata = 32'h0; xfer_done = 1'b1;
        chk("wr_t2_valid", 32'(a_valid), 32'd1);
        chk("wr_t2_rdy", 32'(a_rdy), 32'd0);
        chk("wr_t2_wdata", a_pwdata, 32'hDEAD_BEEF);
        step();
        xfer_done = 1'b0;
        chk("wr_t3_rdy", 32'(a_rdy), 32'd1);
        chk("wr_t3_valid", 32'(a_valid), 32'd0);
        chk("wr_t3_hsel", 32'(a_sel), 32'd0);
        chk("wr_t3_rdata", a_rdata, 32'd0);
        // mapped read, XFER_DONE at T5
        htrans = 2'b10; haddr = 32'h0003_0000; hwrite = 1'b0;
        step();
        htrans = 2'b00;
        chk("rd_t1_hsel", 32'(a_sel), 32'h8);
        chk("rd_t1_wreg", 32'(a_wreg), 32'd0);
        for (int t = 2; t <= 5; t++) begin
            step();
            chk($sformatf("rd_t%0d_valid", t), 32'(a_valid), 32'd1);
            chk($sformatf("rd_t%0d_rdy", t), 32'(a_rdy), 32'd0);
        end
        chk("rd_t5_hsel", 32'(a_sel), 32'h8);
        chk("rd_t5_wdata_hold", a_pwdata, 32'hDEAD_BEEF);
        xfer_done = 1'b1; prdata = 32'h1234_5678;
        step();
        xfer_done = 1'b0; prdata = 32'h0;
        chk("rd_t6_rdata", a_rdata, 32'h1234_5678);
        chk("rd_t6_rdy", 32'(a_rdy), 32'd1);
        chk("rd_t6_valid", 32'(a_valid), 32'd0);
        // unmapped access
        htrans = 2'b10; haddr = 32'h0004_0000; hwrite = 1'b0;
        step();
        htrans = 2'b00;
        chk("um_t1_resp", 32'(a_resp), 32'(err_resp));
        chk("um_t1_rdy", 32'(a_rdy), 32'(err_rdy1));
        chk("um_t1_hsel", 32'(a_sel), 32'd0);
        chk("um_t1_valid", 32'(a_valid), 32'd0);
        chk("um_t1_addr_hold", a_paddr, 32'h0003_0000);
        step();
        chk("um_t2_resp", 32'(a_resp), 32'(err_resp));
        chk("um_t2_rdy", 32'(a_rdy), 32'd1);
        chk("um_t2_valid", 32'(a_valid), 32'd0);
        step();
        chk("um_t3_resp", 32'(a_resp), 32'd0);
        chk("um_t3_rdy", 32'(a_rdy), 32'd1);
        chk("um_t3_rdata", a_rdata, 32'h1234_5678);
        // IDLE/BUSY and not-ready transfers are ignored, as is XFER_DONE in IDLE
        haddr = 32'h0001_0000; xfer_done = 1'b1;
        for (int k = 0; k < 3; k++) begin
            htrans = (k == 2) ? 2'b10 : 2'(k);
            hreadyin = (k != 2);
            step();
            chk($sformatf("ign%0d_rdy", k), 32'(a_rdy), 32'd1);
            chk($sformatf("ign%0d_valid", k), 32'(a_valid), 32'd0);
            chk($sformatf("ign%0d_hsel", k), 32'(a_sel), 32'd0);
        end
        htrans = 2'b00; hreadyin = 1'b1; xfer_done = 1'b0;
        chk("ign_rdata", a_rdata, 32'h1234_5678);
        // reset while waiting for APB
        htrans = 2'b10; haddr = 32'h0002_0000; hwrite = 1'b1;
        step();
        htrans = 2'b00; hwdata = 32'h5555_AAAA;
        step();
        chk("rs_pre_valid", 32'(a_valid), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("rs_valid", 32'(a_valid), 32'd0);
        chk("rs_hsel", 32'(a_sel), 32'd0);
        chk("rs_rdy", 32'(a_rdy), 32'd1);
        chk("rs_addr", a_paddr, 32'd0);
        chk("rs_rdata", a_rdata, 32'd0);
        #1 rst = 1'b0;
        step();
        htrans = 2'b11; haddr = 32'h0000_0010; hwrite = 1'b0;
        step();
        htrans = 2'b00;
        chk("rs2_t1_hsel", 32'(a_sel), 32'h1);
        step();
        chk("rs2_t2_valid", 32'(a_valid), 32'd1);
        xfer_done = 1'b1; prdata = 32'hCAFE_F00D;
        step();
        xfer_done = 1'b0;
        chk("rs2_t3_rdata", a_rdata, 32'hCAFE_F00D);
        chk("rs2_t3_rdy", 32'(a_rdy), 32'd1);
        // eight 4 KiB windows at 0x4000_0000
        htrans = 2'b10; haddr = 32'h4000_7FFC; hwrite = 1'b0;
        step();
        htrans = 2'b00;
        chk("w8_top_hsel", 32'(b_sel), 32'h80);
        chk("w8_top_rdy", 32'(b_rdy), 32'd0);
        step();
        chk("w8_top_valid", 32'(b_valid), 32'd1);
        xfer_done = 1'b1; prdata = 32'h0BAD_CAFE;
        step();
        xfer_done = 1'b0;
        chk("w8_top_rdata", b_rdata, 32'h0BAD_CAFE);
        step();
        step();
        for (int k = 0; k < 2; k++) begin
            htrans = 2'b10; haddr = (k == 0) ? 32'h4000_8000 : 32'h3FFF_FFFC;
            step();
            htrans = 2'b00;
            chk($sformatf("w8_um%0d_hsel", k), 32'(b_sel), 32'd0);
            chk($sformatf("w8_um%0d_resp", k), 32'(b_resp), 32'(err_resp));
            chk($sformatf("w8_um%0d_rdy", k), 32'(b_rdy), 32'(err_rdy1));
            step();
            chk($sformatf("w8_um%0d_valid", k), 32'(b_valid), 32'd0);
            step();
            step();
        end
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/ahb_bridge_slave_if.md
# ahb_bridge_slave_if

Parametrised AHB-Lite slave front end for the AHB-to-APB bridge. It decodes the AHB address into a configurable number of APB slave windows and registers the address, write data, direction and size. It presents a VALID/XFER_DONE handshake to the APB-side FSM and inserts AHB wait states until the APB transfer completes. Read data is returned on HRDATA, and unmapped accesses optionally get a two-cycle ERROR response.

## Interface
- ADDR_W, 32: AHB address width.
- DATA_W, 32: AHB/APB data width.
- NUM_SLV, 4: number of APB slave windows; HSEL width; 1..16.
- BASE_ADDR, 32'h0000_0000: start of window 0.
- SLV_AW, 16: log2 of window size in bytes; window i = [BASE_ADDR + i·2^SLV_AW, BASE_ADDR + (i+1)·2^SLV_AW − 1].

- HCLK  in  1  bus clock; all state on rising edge.
- HRESET  in  1  asynchronous, active-high reset.
- HREADYIN  in  1  AHB HREADY from the interconnect.
- HTRANS  in  2  transfer type; NONSEQ=2'b10, SEQ=2'b11 valid; IDLE/BUSY ignored.
- HADDR  in  ADDR_W  address-phase address.
- HWRITE  in  1  address-phase direction.
- HSIZE  in  3  address-phase size.
- HWDATA  in  DATA_W  data-phase write data.
- XFER_DONE  in  1  APB FSM: current transfer finished.
- PRDATA_IN  in  DATA_W  APB read data, valid with XFER_DONE.
- HREADYOUT  out  1  registered; 0 = wait state.
- HRESP  out  2  registered; OKAY=2'b00, ERROR=2'b01.
- HRDATA  out  DATA_W  registered read data.
- PIPELINE_HADDR  out  ADDR_W  captured address.
- PIPELINE_HWDATA  out  DATA_W  captured write data.
- HWRITEREG  out  1  captured HWRITE.
- HSIZEREG  out  3  captured HSIZE.
- HSEL  out  NUM_SLV  one-hot APB slave select.
- VALID  out  1  transfer pending for APB FSM.

## Operation
- States: IDLE, DPH, WAITX, ERR1, ERR2.
- Accept: HREADYIN & HREADYOUT & HTRANS∈{NONSEQ,SEQ}; only evaluated in IDLE or ERR2.
- Mapped address: window index = (HADDR − BASE_ADDR) >> SLV_AW, and the index is < NUM_SLV.
- Mapped accept: capture HADDR/HWRITE/HSIZE, set HSEL one-hot, →DPH.
- DPH: HREADYOUT=0; capture HWDATA into PIPELINE_HWDATA on writes; →WAITX.
- WAITX: VALID=1, HREADYOUT=0, HSEL held.
  - On XFER_DONE: HRDATA←PRDATA_IN (reads only), →IDLE.
- IDLE: HREADYOUT=1, VALID=0, HSEL=0. PIPELINE_* hold last values.
- XFER_DONE outside WAITX is ignored.
- Unmapped accept: behaviour set by the macro (see Configuration).
- ERR1: HRESP=ERROR, HREADYOUT=0; →ERR2.
- ERR2: HRESP=ERROR, HREADYOUT=1; accepts like IDLE, else →IDLE.
- Address arithmetic is done in ADDR_W+1 bits. Addresses below BASE_ADDR are unmapped; no wrap-around.
- Reset values: HREADYOUT=1, HRESP=OKAY, VALID=0, HSEL=0, state IDLE; all data/address registers 0.
- Reset mid-transfer clears everything immediately, with VALID dropping asynchronously. The pending APB transfer is abandoned.

## Timing
- T0: address phase accepted.
- T1: DPH; HREADYOUT=0; PIPELINE_HADDR/HSEL/HWRITEREG valid.
- T2: WAITX; VALID=1; PIPELINE_HWDATA valid.
- XFER_DONE sampled at Tk → Tk+1: HREADYOUT=1, VALID=0, HRDATA valid. Minimum transfer is 3 cycles, with XFER_DONE at T2.
- Back-to-back: next address phase may be accepted in the Tk+1 cycle.
- Error: T1 ERR1, T2 ERR2 (HREADYOUT=1), T3 IDLE, HRESP=OKAY.

## Configuration
- AHB_SLV_ERR_RESP_EN defined: unmapped accepted transfers take the ERR1→ERR2 two-cycle ERROR response.
- Not defined: unmapped transfers are not accepted. HREADYOUT stays 1, HRESP stays OKAY, state stays IDLE, no VALID, writes are dropped, and HRDATA is unchanged. ERR1/ERR2 do not exist and HRESP is constant OKAY.

## Test plan
- Write 0x0001_0004 (default params), HWDATA=0xDEAD_BEEF, XFER_DONE at T2 -> HSEL=4'b0010, PIPELINE_HWDATA=0xDEAD_BEEF, VALID for 1 cycle, HREADYOUT low T1–T2, high T3.
- Read 0x0003_0000, PRDATA_IN=0x1234_5678, XFER_DONE at T5 -> HSEL=4'b1000, VALID T2–T5, HRDATA=0x1234_5678 and HREADYOUT=1 at T6.
- Access 0x0004_0000 with macro defined -> HRESP=ERROR T1–T2, HREADYOUT 0 then 1, HSEL=0, VALID never set. Without macro -> HREADYOUT stays 1, HRESP OKAY.
- HTRANS=IDLE/BUSY at mapped address, and XFER_DONE pulsed in IDLE -> no state change, VALID=0.
- HRESET asserted during WAITX -> same-cycle VALID=0, HSEL=0, HREADYOUT=1. The next accepted transfer completes normally.
- NUM_SLV=8, SLV_AW=12, BASE_ADDR=0x4000_0000: 0x4000_7FFC -> HSEL=8'h80; 0x4000_8000 -> unmapped.
